// File: rtl/ofmap_drain.sv
// Two-bank psum accumulator and ofmap serializer. One bank accumulates psum vectors across all
// passes of a tile while the other drains its finished tile onto the 32-bit ofmap stream.
module ofmap_drain #(
  parameter int unsigned OFMAP_WIDTH    = 32,
  parameter int unsigned ARRAY_WIDTH    = 4,
  parameter int unsigned ACC_ADDR_COUNT = 9,
  parameter int unsigned ACC_PASSES     = 18
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [OFMAP_WIDTH*ARRAY_WIDTH-1:0] psum_dat,
  input  logic                               psum_vld,
  output logic                               psum_rdy,
  output logic [OFMAP_WIDTH-1:0]             ofmap_dat,
  output logic                               ofmap_vld,
  input  logic                               ofmap_rdy,
  output logic                               tile_done
);

  localparam int unsigned AddrW = (ACC_ADDR_COUNT > 1) ? $clog2(ACC_ADDR_COUNT) : 1;
  localparam int unsigned LaneW = (ARRAY_WIDTH > 1) ? $clog2(ARRAY_WIDTH) : 1;
  localparam int unsigned PassW = (ACC_PASSES > 1) ? $clog2(ACC_PASSES) : 1;

  localparam logic [AddrW-1:0] AddrLast = AddrW'(ACC_ADDR_COUNT - 1);
  localparam logic [LaneW-1:0] LaneLast = LaneW'(ARRAY_WIDTH - 1);
  localparam logic [PassW-1:0] PassLast = PassW'(ACC_PASSES - 1);

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  state_e state_q, state_d;

  logic [OFMAP_WIDTH-1:0] bank_q [2][ACC_ADDR_COUNT][ARRAY_WIDTH];

  logic [AddrW-1:0] acc_addr_q, dr_addr_q;
  logic [LaneW-1:0] dr_lane_q;
  logic [PassW-1:0] acc_pass_q;
  logic             acc_full_q;
  logic             bank_sel_q;
  logic             tile_done_q;

  logic                   beat, swap, hs, last_word, drain_sel;
  logic [OFMAP_WIDTH-1:0] rd_word;

  assign psum_rdy  = ~acc_full_q;
  assign beat      = psum_vld & psum_rdy;
  assign swap      = (state_q == StIdle) & acc_full_q;
  assign hs        = ofmap_vld & ofmap_rdy;
  assign last_word = hs & (dr_addr_q == AddrLast) & (dr_lane_q == LaneLast);
  assign drain_sel = ~bank_sel_q;
  assign rd_word   = bank_q[drain_sel][dr_addr_q][dr_lane_q];
  assign tile_done = tile_done_q;

  // Bank contents are deliberately not reset: pass 0 always overwrites before any read.
  always_ff @(posedge clk) begin
    if (beat) begin
      for (int k = 0; k < ARRAY_WIDTH; k++) begin
        if (acc_pass_q == '0) begin
          bank_q[bank_sel_q][acc_addr_q][k] <= psum_dat[k*OFMAP_WIDTH +: OFMAP_WIDTH];
        end else begin
          bank_q[bank_sel_q][acc_addr_q][k] <= bank_q[bank_sel_q][acc_addr_q][k] +
                                              psum_dat[k*OFMAP_WIDTH +: OFMAP_WIDTH];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_addr_q  <= '0;
      acc_pass_q  <= '0;
      acc_full_q  <= 1'b0;
      bank_sel_q  <= 1'b0;
      dr_addr_q   <= '0;
      dr_lane_q   <= '0;
      tile_done_q <= 1'b0;
    end else begin
      if (beat) begin
        if (acc_addr_q == AddrLast) begin
          acc_addr_q <= '0;
          if (acc_pass_q == PassLast) begin
            acc_pass_q <= '0;
            acc_full_q <= 1'b1;
          end else begin
            acc_pass_q <= acc_pass_q + 1'b1;
          end
        end else begin
          acc_addr_q <= acc_addr_q + 1'b1;
        end
      end
      // A swap can only happen while acc_full is set, so it never coincides with a beat.
      if (swap) begin
        bank_sel_q <= ~bank_sel_q;
        acc_full_q <= 1'b0;
        dr_addr_q  <= '0;
        dr_lane_q  <= '0;
      end else if (hs) begin
        if (dr_lane_q == LaneLast) begin
          dr_lane_q <= '0;
          dr_addr_q <= (dr_addr_q == AddrLast) ? '0 : dr_addr_q + 1'b1;
        end else begin
          dr_lane_q <= dr_lane_q + 1'b1;
        end
      end
      tile_done_q <= last_word;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (acc_full_q) state_d = StSend;
      StSend:  if (last_word) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    ofmap_vld = (state_q == StSend);
    ofmap_dat = ofmap_vld ? rd_word : '0;
  end

endmodule

// File: tb/tb_ofmap_drain.sv
// Bench for ofmap_drain: directed and random tiles checked against a per-tile sum model
// that predicts the word sequence, plus stall, gap, tile_done and reset timing checks.
module tb_ofmap_drain;

  localparam int AW = 2;
  localparam int AC = 2;
  localparam int AP = 3;
  localparam int W  = AW * AC;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [63:0]   psum_dat = '0;
  logic          psum_vld = 1'b0;
  logic          psum_rdy;
  logic [31:0]   ofmap_dat;
  logic          ofmap_vld;
  logic          ofmap_rdy = 1'b0;
  logic          tile_done;

  ofmap_drain #(
    .OFMAP_WIDTH   (32),
    .ARRAY_WIDTH   (AW),
    .ACC_ADDR_COUNT(AC),
    .ACC_PASSES    (AP)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .psum_dat (psum_dat),
    .psum_vld (psum_vld),
    .psum_rdy (psum_rdy),
    .ofmap_dat(ofmap_dat),
    .ofmap_vld(ofmap_vld),
    .ofmap_rdy(ofmap_rdy),
    .tile_done(tile_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [31:0] exp_q[$];
  logic [31:0] vals [AP][AC][AW];

  int beat_edge = 0, last_rise = 0, last_fall = 0, last_gap = 0;
  int hs_first = 0, hs_last = 0, done_due = -1, drained = 0;
  int rdy_mode = 0, rdy_phase = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // ofmap_rdy driver: 0 always, 1 random, 2 pattern 1,0,0, 3 held low
  initial forever begin
    @(posedge clk);
    #1;
    case (rdy_mode)
      0: ofmap_rdy = 1'b1;
      1: ofmap_rdy = 1'($urandom_range(0, 1));
      2: begin
        ofmap_rdy = (rdy_phase % 3 == 0);
        rdy_phase++;
      end
      default: ofmap_rdy = 1'b0;
    endcase
  end

  // Output monitor, sampled mid-cycle; a handshake seen at cycle n lands on edge n+1.
  initial begin
    logic        prev_vld;
    logic        prev_stall;
    logic [31:0] prev_dat;
    logic [31:0] e;
    prev_vld = 1'b0;
    prev_stall = 1'b0;
    prev_dat = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_vld = 1'b0;
        prev_stall = 1'b0;
        drained = 0;
        done_due = -1;
      end else begin
        check("tile_done", {31'b0, tile_done}, {31'b0, cyc == done_due});
        if (ofmap_vld && !prev_vld) begin
          last_gap = cyc - last_fall;
          last_rise = cyc;
          check("rdy_at_swap", {31'b0, psum_rdy}, 32'd1);
        end
        if (!ofmap_vld && prev_vld) last_fall = cyc;
        if (prev_stall) begin
          check("hold_vld", {31'b0, ofmap_vld}, 32'd1);
          check("hold_dat", ofmap_dat, prev_dat);
        end
        if (!ofmap_vld) check("dat_idle", ofmap_dat, 32'd0);
        if (ofmap_vld && ofmap_rdy) begin
          if (exp_q.size() == 0) begin
            check("word_expected", 32'(exp_q.size()), 32'd1);
          end else begin
            e = exp_q.pop_front();
            check("word", ofmap_dat, e);
          end
          if (drained == 0) hs_first = cyc + 1;
          if (drained == W - 1) begin
            hs_last = cyc + 1;
            done_due = cyc + 1;
            drained = 0;
          end else begin
            drained++;
          end
        end
        prev_vld = ofmap_vld;
        prev_stall = ofmap_vld && !ofmap_rdy;
        prev_dat = ofmap_dat;
      end
    end
  end

  task automatic wait_beat();
    int  t;
    bit  done;
    t = 0;
    done = 0;
    while (!done) begin
      @(negedge clk);
      if (psum_rdy) begin
        done = 1;
      end else begin
        t++;
        if (t > 300) begin
          check("beat_timeout", {31'b0, psum_rdy}, 32'd1);
          done = 1;
        end else begin
          @(posedge clk);
          #1;
        end
      end
    end
    @(posedge clk);
    #1;
    beat_edge = cyc;
  endtask

  // gap_mode: 0 none, 1 idle cycle before every beat, 2 random idle cycles
  task automatic send_tile(input int gap_mode);
    logic [31:0] s;
    for (int p = 0; p < AP; p++) begin
      for (int a = 0; a < AC; a++) begin
        if (gap_mode == 1 || (gap_mode == 2 && $urandom_range(0, 2) == 0)) begin
          psum_vld = 1'b0;
          psum_dat = {$urandom, $urandom};
          @(posedge clk);
          #1;
        end
        psum_vld = 1'b1;
        psum_dat = {vals[p][a][1], vals[p][a][0]};
        wait_beat();
      end
    end
    psum_vld = 1'b0;
    for (int a = 0; a < AC; a++) begin
      for (int l = 0; l < AW; l++) begin
        s = '0;
        for (int p = 0; p < AP; p++) s = s + vals[p][a][l];
        exp_q.push_back(s);
      end
    end
  endtask

  task automatic wait_drained();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 400) begin
      @(posedge clk);
      #1;
      t++;
    end
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check("drain_done", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic fill_pass_plus_one();
    for (int p = 0; p < AP; p++)
      for (int a = 0; a < AC; a++)
        for (int l = 0; l < AW; l++) vals[p][a][l] = 32'(p + 1);
  endtask

  task automatic fill_random();
    for (int p = 0; p < AP; p++)
      for (int a = 0; a < AC; a++)
        for (int l = 0; l < AW; l++) vals[p][a][l] = $urandom;
  endtask

  initial begin
    int t;
    #3;
    check("rst_vld", {31'b0, ofmap_vld}, 32'd0);
    check("rst_dat", ofmap_dat, 32'd0);
    check("rst_done", {31'b0, tile_done}, 32'd0);
    check("rst_rdy", {31'b0, psum_rdy}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Constant passes, full-rate drain
    rdy_mode = 0;
    fill_pass_plus_one();
    send_tile(0);
    wait_drained();
    check("vld_rise_lat", 32'(last_rise - beat_edge), 32'd1);
    check("burst_span", 32'(hs_last - hs_first), 32'd3);

    // Address/lane-coded values under a stalling sink
    rdy_mode = 2;
    rdy_phase = 0;
    for (int p = 0; p < AP; p++)
      for (int a = 0; a < AC; a++)
        for (int l = 0; l < AW; l++) vals[p][a][l] = 32'(a * 10 + l);
    send_tile(0);
    wait_drained();

    // Wraparound accumulation
    rdy_mode = 0;
    for (int a = 0; a < AC; a++)
      for (int l = 0; l < AW; l++) begin
        vals[0][a][l] = 32'hFFFF_FFFF;
        vals[1][a][l] = 32'd2;
        vals[2][a][l] = 32'd0;
      end
    send_tile(0);
    wait_drained();

    // Second tile completes while the first is stuck in the drain
    rdy_mode = 3;
    fill_random();
    send_tile(2);
    fill_random();
    send_tile(2);
    check("rdy_blocked", {31'b0, psum_rdy}, 32'd0);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check("rdy_still_blocked", {31'b0, psum_rdy}, 32'd0);
    rdy_mode = 0;
    wait_drained();
    check("b2b_gap", 32'(last_gap), 32'd1);
    check("rdy_restored", {31'b0, psum_rdy}, 32'd1);

    // Reset after two words of a tile
    fill_random();
    send_tile(0);
    t = 0;
    while (exp_q.size() > W - 2 && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("pre_reset_words", 32'(exp_q.size()), 32'(W - 2));
    rst_n = 1'b0;
    #1;
    check("mid_rst_vld", {31'b0, ofmap_vld}, 32'd0);
    check("mid_rst_rdy", {31'b0, psum_rdy}, 32'd1);
    check("mid_rst_dat", ofmap_dat, 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int p = 0; p < AP; p++)
      for (int a = 0; a < AC; a++)
        for (int l = 0; l < AW; l++) vals[p][a][l] = 32'd1;
    send_tile(0);
    wait_drained();

    // Alternating psum_vld
    fill_pass_plus_one();
    send_tile(1);
    wait_drained();
    check("gap_vld_rise_lat", 32'(last_rise - beat_edge), 32'd1);

    // Random tiles, random sink, random gaps, overlapping drains
    rdy_mode = 1;
    for (int n = 0; n < 8; n++) begin
      fill_random();
      send_tile(2);
      if (n % 3 == 2) wait_drained();
    end
    wait_drained();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
